// File: rtl/jtag_pkg.sv
// Shared constants for the JTAG instruction/data register path.
// Opcodes are plain ints so each user can size them to its own IR width.
package jtag_pkg;

    localparam int OP_BYPASS = -1;  // all ones at any IR width once truncated
    localparam int OP_IDCODE = 1;
    localparam int OP_USER   = 2;

    localparam logic [1:0]  IR_CAPTURE     = 2'b01;
    localparam logic [31:0] IDCODE_DEFAULT = 32'h1234_5679;

    typedef enum logic [1:0] {
        DR_BYPASS,
        DR_IDCODE,
        DR_USER
    } dr_sel_e;

endpackage

// File: rtl/jtag_shift_reg.sv
// Generic JTAG shift register: capture / shift-right (tdi in at MSB) / update.
// lsb only moves on posedge tck, so it is stable when sampled on negedge.
module jtag_shift_reg #(
    parameter int           W      = 8,
    parameter logic [W-1:0] SR_RST = '0,
    parameter logic [W-1:0] Q_RST  = '0
) (
    input  logic         tck,
    input  logic         trst,
    input  logic         capture,
    input  logic         shift,
    input  logic         update,
    input  logic         tdi,
    input  logic [W-1:0] cap_val,
    output logic [W-1:0] q,
    output logic         lsb
);

    logic [W-1:0] sr;
    logic [W-1:0] shifted;

    if (W == 1) begin : g_one
        assign shifted = tdi;
    end else begin : g_wide
        assign shifted = {tdi, sr[W-1:1]};
    end

    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge tck or negedge trst) begin
        if (!trst) begin
            sr <= SR_RST;
        end else if (capture) begin
            sr <= cap_val;
        end else if (shift) begin
            sr <= shifted;
        end
    end

    always_ff @(posedge tck or negedge trst) begin
        if (!trst) begin
            q <= Q_RST;
        end else if (update && !capture && !shift) begin
            q <= sr;
        end
    end

    assign lsb = sr[0];

endmodule

// File: rtl/jtag_reg_path.sv
// JTAG IR/DR datapath behind the TAP controller; TDO launched on falling TCK.
// Define JTAG_IDCODE_EN to build the IDCODE register and make it the reset instruction.
module jtag_reg_path
    import jtag_pkg::*;
#(
    parameter int          IR_W       = 4,
    parameter int          USER_W     = 8,
    parameter logic [31:0] IDCODE_VAL = IDCODE_DEFAULT
) (
    input  logic              tck,
    input  logic              trst,
    input  logic              tdi,
    input  logic              cir1,
    input  logic              sir1,
    input  logic              uir1,
    input  logic              cdr1,
    input  logic              sdr1,
    input  logic              udr1,
    output logic              tdo,
    output logic              tdo_en,
    output logic [IR_W-1:0]   ir_q,
    output logic [USER_W-1:0] user_q,
    output logic              user_upd,
    input  logic [USER_W-1:0] user_in
);

    localparam logic [IR_W-1:0] IR_CAP     = IR_W'(IR_CAPTURE);
    localparam logic [IR_W-1:0] OPC_BYPASS = IR_W'(OP_BYPASS);
    localparam logic [IR_W-1:0] OPC_IDCODE = IR_W'(OP_IDCODE);
    localparam logic [IR_W-1:0] OPC_USER   = IR_W'(OP_USER);
`ifdef JTAG_IDCODE_EN
    localparam logic [IR_W-1:0] IR_RST = OPC_IDCODE;
`else
    localparam logic [IR_W-1:0] IR_RST = OPC_BYPASS;
`endif

    // Any IR strobe suppresses the DR group, so one action per cycle at most.
    logic ir_busy, dr_cap, dr_shift, dr_upd;
    assign ir_busy  = cir1 | sir1 | uir1;
    assign dr_cap   = cdr1 & ~ir_busy;
    assign dr_shift = sdr1 & ~ir_busy & ~cdr1;
    assign dr_upd   = udr1 & ~ir_busy & ~cdr1 & ~sdr1;

    logic ir_lsb;
    jtag_shift_reg #(.W(IR_W), .SR_RST(IR_CAP), .Q_RST(IR_RST)) u_ir (
        .tck(tck), .trst(trst), .capture(cir1), .shift(sir1), .update(uir1),
        .tdi(tdi), .cap_val(IR_CAP), .q(ir_q), .lsb(ir_lsb)
    );

    dr_sel_e dr_sel;
    // NOTE: default first in always_comb so no path leaves dr_sel unassigned (no latch).
    always_comb begin
        dr_sel = DR_BYPASS;
        if (ir_q == OPC_USER) begin
            dr_sel = DR_USER;
        end
`ifdef JTAG_IDCODE_EN
        else if (ir_q == OPC_IDCODE) begin
            dr_sel = DR_IDCODE;
        end
`endif
    end

    logic usr_lsb, usr_upd;
    assign usr_upd = dr_upd & (dr_sel == DR_USER);
    jtag_shift_reg #(.W(USER_W)) u_user (
        .tck(tck), .trst(trst),
        .capture(dr_cap & (dr_sel == DR_USER)),
        .shift(dr_shift & (dr_sel == DR_USER)),
        .update(usr_upd),
        .tdi(tdi), .cap_val(user_in), .q(user_q), .lsb(usr_lsb)
    );

`ifdef JTAG_IDCODE_EN
    logic        id_lsb;
    logic [31:0] id_unused;
    jtag_shift_reg #(.W(32), .SR_RST(IDCODE_VAL), .Q_RST(IDCODE_VAL)) u_id (
        .tck(tck), .trst(trst),
        .capture(dr_cap & (dr_sel == DR_IDCODE)),
        .shift(dr_shift & (dr_sel == DR_IDCODE)),
        .update(1'b0),
        .tdi(tdi), .cap_val(IDCODE_VAL), .q(id_unused), .lsb(id_lsb)
    );
`else
    logic id_unused;
    assign id_unused = ^IDCODE_VAL;
`endif

    logic byp;
    always_ff @(posedge tck or negedge trst) begin
        if (!trst) begin
            byp      <= 1'b0;
            user_upd <= 1'b0;
        end else begin
            user_upd <= usr_upd;
            if (dr_sel == DR_BYPASS) begin
                if (dr_cap) begin
                    byp <= 1'b0;
                end else if (dr_shift) begin
                    byp <= tdi;
                end
            end
        end
    end

    logic dr_lsb;
    always_comb begin
        dr_lsb = byp;
        case (dr_sel)
            DR_USER:   dr_lsb = usr_lsb;
`ifdef JTAG_IDCODE_EN
            DR_IDCODE: dr_lsb = id_lsb;
`endif
            default:   dr_lsb = byp;
        endcase
    end

    // Falling-edge launch gives the far end a full half-cycle of setup before its rising edge.
    always_ff @(negedge tck or negedge trst) begin
        if (!trst) begin
            tdo    <= 1'b0;
            tdo_en <= 1'b0;
        end else begin
            tdo    <= sir1 ? ir_lsb : (sdr1 ? dr_lsb : 1'b0);
            tdo_en <= sir1 | sdr1;
        end
    end

endmodule

// File: tb/tb_jtag_reg_path.sv
// Self-checking bench for jtag_reg_path: vector table, hand-written corner sequences
// and a randomized run against a behavioural register model.
module tb_jtag_reg_path;

`ifdef JTAG_IDCODE_EN
    localparam bit HAS_ID = 1'b1;
`else
    localparam bit HAS_ID = 1'b0;
`endif
    localparam int          IR_W   = 4;
    localparam int          USER_W = 8;
    localparam logic [31:0] IDC    = 32'h1234_5679;
    localparam logic [3:0]  IR_RST = HAS_ID ? 4'd1 : 4'hF;

    localparam logic [5:0] S_CIR = 6'b100000;
    localparam logic [5:0] S_SIR = 6'b010000;
    localparam logic [5:0] S_UIR = 6'b001000;
    localparam logic [5:0] S_CDR = 6'b000100;
    localparam logic [5:0] S_SDR = 6'b000010;
    localparam logic [5:0] S_UDR = 6'b000001;
    localparam logic [5:0] S_IDL = 6'b000000;

    logic       tck = 1'b0;
    logic       trst, tdi, cir1, sir1, uir1, cdr1, sdr1, udr1;
    logic       tdo, tdo_en, user_upd;
    logic [3:0] ir_q;
    logic [7:0] user_q, user_in;

    always #5 tck = ~tck;

    jtag_reg_path #(.IR_W(IR_W), .USER_W(USER_W), .IDCODE_VAL(IDC)) dut (
        .tck(tck), .trst(trst), .tdi(tdi),
        .cir1(cir1), .sir1(sir1), .uir1(uir1),
        .cdr1(cdr1), .sdr1(sdr1), .udr1(udr1),
        .tdo(tdo), .tdo_en(tdo_en), .ir_q(ir_q),
        .user_q(user_q), .user_upd(user_upd), .user_in(user_in)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Behavioural model: registers as plain integers, updated by the written rules.
    int unsigned m_ir_sr, m_ir_q, m_byp, m_id, m_usr, m_user_q, m_upd;

    function automatic void model_reset();
        m_ir_sr = 1; m_ir_q = IR_RST; m_byp = 0; m_id = IDC;
        m_usr = 0; m_user_q = 0; m_upd = 0;
    endfunction

    function automatic void model_step(input logic [5:0] s, input logic t, input logic [7:0] uin,
                                       output logic e_tdo, output logic e_en);
        int unsigned kind, lsb, ti;
        ti   = {31'd0, t};
        kind = (m_ir_q == 2) ? 2 : ((HAS_ID && m_ir_q == 1) ? 1 : 0);
        lsb  = (kind == 2) ? (m_usr & 1) : ((kind == 1) ? (m_id & 1) : m_byp);
        e_tdo = s[4] ? m_ir_sr[0] : (s[1] ? lsb[0] : 1'b0);
        e_en  = s[4] | s[1];
        m_upd = 0;
        if (s[5])      m_ir_sr = 1;
        else if (s[4]) m_ir_sr = (m_ir_sr >> 1) | (ti << (IR_W - 1));
        else if (s[3]) m_ir_q  = m_ir_sr;
        else if (s[2]) begin
            if (kind == 0) m_byp = 0;
            else if (kind == 1) m_id = IDC;
            else m_usr = uin;
        end else if (s[1]) begin
            if (kind == 0) m_byp = ti;
            else if (kind == 1) m_id = (m_id >> 1) | (ti << 31);
            else m_usr = (m_usr >> 1) | (ti << (USER_W - 1));
        end else if (s[0] && kind == 2) begin
            m_user_q = m_usr;
            m_upd    = 1;
        end
    endfunction

    // Called at posedge+1; returns tdo/tdo_en seen after the falling edge of this cycle.
    task automatic tick(input logic [5:0] s, input logic t, output logic o_tdo, output logic o_en);
        {cir1, sir1, uir1, cdr1, sdr1, udr1} = s;
        tdi = t;
        @(negedge tck); #1;
        o_tdo = tdo;
        o_en  = tdo_en;
        @(posedge tck); #1;
    endtask

    task automatic do_reset(input string tag);
        {cir1, sir1, uir1, cdr1, sdr1, udr1} = S_IDL;
        tdi  = 1'b0;
        trst = 1'b0;
        repeat (2) @(posedge tck);
        #2;
        check({tag, " tdo"}, tdo, 1'b0);
        check({tag, " tdo_en"}, tdo_en, 1'b0);
        check({tag, " ir_q"}, ir_q, IR_RST);
        check({tag, " user_q"}, user_q, 8'h00);
        check({tag, " user_upd"}, user_upd, 1'b0);
        trst = 1'b1;
        @(posedge tck); #1;
        model_reset();
    endtask

    typedef struct {
        logic [5:0] stb;
        logic       tdi;
        logic       tdo;
        logic [3:0] ir;
        logic [7:0] uq;
        logic       upd;
    } vec_t;
    vec_t tbl[$];

    function automatic void add(input logic [5:0] s, input logic t, input logic o,
                                input logic [3:0] ir, input logic [7:0] uq, input logic up);
        vec_t v;
        v.stb = s; v.tdi = t; v.tdo = o; v.ir = ir; v.uq = uq; v.upd = up;
        tbl.push_back(v);
    endfunction

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        logic       o_tdo, o_en, e_tdo, e_en;
        logic [7:0] pat_in, pat_out;
        logic [3:0] ir_pat;
        logic [4:0] byp_in, byp_out;
        logic [3:0] ill_in, ill_out;
        logic [33:0] scan_tdi;
        logic [5:0] s;
        int r;

        // Table: USER load/scan/update, BYPASS scan, illegal opcode, priority cases.
        ir_pat = 4'b0010;
        add(S_CIR, 0, 0, IR_RST, 8'h00, 0);
        for (int i = 0; i < 4; i++) add(S_SIR, ir_pat[i], (i == 0), IR_RST, 8'h00, 0);
        add(S_UIR, 0, 0, 4'd2, 8'h00, 0);
        add(S_CDR, 0, 0, 4'd2, 8'h00, 0);
        pat_in = 8'h3C; pat_out = 8'hA5;
        for (int i = 0; i < 8; i++) add(S_SDR, pat_in[i], pat_out[i], 4'd2, 8'h00, 0);
        add(S_UDR, 0, 0, 4'd2, 8'h3C, 1);
        add(S_IDL, 0, 0, 4'd2, 8'h3C, 0);
        add(S_CIR, 0, 0, 4'd2, 8'h3C, 0);
        for (int i = 0; i < 4; i++) add(S_SIR, 1, (i == 0), 4'd2, 8'h3C, 0);
        add(S_UIR, 0, 0, 4'hF, 8'h3C, 0);
        add(S_CDR, 0, 0, 4'hF, 8'h3C, 0);
        byp_in = 5'b01101; byp_out = 5'b11010;
        for (int i = 0; i < 5; i++) add(S_SDR, byp_in[i], byp_out[i], 4'hF, 8'h3C, 0);
        add(S_UDR, 0, 0, 4'hF, 8'h3C, 0);
        ir_pat = 4'b0111;
        add(S_CIR, 0, 0, 4'hF, 8'h3C, 0);
        for (int i = 0; i < 4; i++) add(S_SIR, ir_pat[i], (i == 0), 4'hF, 8'h3C, 0);
        add(S_UIR, 0, 0, 4'd7, 8'h3C, 0);
        add(S_CDR, 0, 0, 4'd7, 8'h3C, 0);
        ill_in = 4'b1011; ill_out = 4'b0110;
        for (int i = 0; i < 4; i++) add(S_SDR, ill_in[i], ill_out[i], 4'd7, 8'h3C, 0);
        add(S_CDR | S_SDR | S_UDR, 1, 1, 4'd7, 8'h3C, 0);
        add(S_SDR, 0, 0, 4'd7, 8'h3C, 0);
        add(S_CIR | S_SDR, 1, 0, 4'd7, 8'h3C, 0);
        add(S_SDR, 0, 0, 4'd7, 8'h3C, 0);

        user_in = 8'hA5;
        do_reset("reset0");

        for (int i = 0; i < tbl.size(); i++) begin
            tick(tbl[i].stb, tbl[i].tdi, o_tdo, o_en);
            check($sformatf("tbl[%0d] tdo", i), o_tdo, tbl[i].tdo);
            check($sformatf("tbl[%0d] tdo_en", i), o_en, tbl[i].stb[4] | tbl[i].stb[1]);
            check($sformatf("tbl[%0d] ir_q", i), ir_q, tbl[i].ir);
            check($sformatf("tbl[%0d] user_q", i), user_q, tbl[i].uq);
            check($sformatf("tbl[%0d] user_upd", i), user_upd, tbl[i].upd);
        end

        // Asynchronous reset in the middle of a USER DR scan.
        do_reset("reset1");
        ir_pat = 4'b0010;
        tick(S_CIR, 0, o_tdo, o_en);
        for (int i = 0; i < 4; i++) tick(S_SIR, ir_pat[i], o_tdo, o_en);
        tick(S_UIR, 0, o_tdo, o_en);
        user_in = 8'h5A;
        tick(S_CDR, 0, o_tdo, o_en);
        pat_out = 8'h5A;
        for (int i = 0; i < 3; i++) begin
            tick(S_SDR, 1, o_tdo, o_en);
            check($sformatf("midrst shift%0d tdo", i), o_tdo, pat_out[i]);
        end
        sdr1 = 1'b1;
        @(negedge tck); #1;
        check("midrst pre tdo_en", tdo_en, 1'b1);
        trst = 1'b0;
        #1;
        check("midrst tdo", tdo, 1'b0);
        check("midrst tdo_en", tdo_en, 1'b0);
        check("midrst ir_q", ir_q, IR_RST);
        check("midrst user_q", user_q, 8'h00);
        check("midrst user_upd", user_upd, 1'b0);
        {cir1, sir1, uir1, cdr1, sdr1, udr1} = S_IDL;
        #1 trst = 1'b1;
        @(posedge tck); #1;

        // First DR scan after reset: IDCODE (or bypass delay), then tdi stream with no wrap.
        scan_tdi = {$urandom, $urandom};
        tick(S_CDR, 0, o_tdo, o_en);
        for (int i = 0; i < 34; i++) begin
            tick(S_SDR, scan_tdi[i], o_tdo, o_en);
            if (HAS_ID) e_tdo = (i < 32) ? IDC[i] : scan_tdi[i - 32];
            else        e_tdo = (i == 0) ? 1'b0 : scan_tdi[i - 1];
            check($sformatf("idscan bit%0d tdo", i), o_tdo, e_tdo);
            check($sformatf("idscan bit%0d tdo_en", i), o_en, 1'b1);
        end
        tick(S_UDR, 0, o_tdo, o_en);
        check("idscan user_q", user_q, 8'h00);
        check("idscan user_upd", user_upd, 1'b0);

        // Randomized run against the model.
        do_reset("reset2");
        for (int n = 0; n < 800; n++) begin
            r = $urandom_range(0, 11);
            if (r < 6)       s = 6'(1 << r);
            else if (r < 9)  s = (r == 6) ? S_IDL : ((r == 7) ? S_SIR : S_SDR);
            else             s = 6'($urandom);
            user_in = 8'($urandom);
            tdi     = 1'($urandom);
            model_step(s, tdi, user_in, e_tdo, e_en);
            tick(s, tdi, o_tdo, o_en);
            check($sformatf("rnd%0d tdo", n), o_tdo, e_tdo);
            check($sformatf("rnd%0d tdo_en", n), o_en, e_en);
            check($sformatf("rnd%0d ir_q", n), ir_q, m_ir_q);
            check($sformatf("rnd%0d user_q", n), user_q, m_user_q);
            check($sformatf("rnd%0d user_upd", n), user_upd, m_upd);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/jtag_reg_path.md
Name: jtag_reg_path

Overview:
- Instruction-register/data-register datapath directly downstream of tap_controller; consumes its per-state strobes (cir1, sir1, uir1, cdr1, sdr1, udr1).
- Holds the IR shift/latch pair, the BYPASS, IDCODE and USER data registers, and the instruction decode.
- Drives TDO on the falling TCK edge and exposes the USER register contents to the core.

Parameters:
- IR_W, 4, instruction register width (>=2).
- USER_W, 8, USER data register width (>=1).
- IDCODE_VAL, 32'h1234_5679, IDCODE register value; bit 0 must be 1.

Ports:
- tck  input  1  JTAG test clock; the only clock.
- trst  input  1  asynchronous, active-low reset.
- tdi  input  1  serial data in.
- cir1  input  1  TAP in Capture-IR.
- sir1  input  1  TAP in Shift-IR.
- uir1  input  1  TAP in Update-IR.
- cdr1  input  1  TAP in Capture-DR.
- sdr1  input  1  TAP in Shift-DR.
- udr1  input  1  TAP in Update-DR.
- tdo  output  1  serial data out, updated on negedge tck.
- tdo_en  output  1  high while shifting, updated on negedge tck.
- ir_q  output  IR_W  latched current instruction.
- user_q  output  USER_W  USER register parallel output.
- user_upd  output  1  one-tck pulse when user_q is loaded.
- user_in  input  USER_W  core value captured into the USER shift register.

Behaviour:
- Opcodes: BYPASS = all ones; IDCODE = 1; USER = 2. Any other code selects BYPASS.
- Strobes are level signals sampled on posedge tck. The TAP guarantees at most one is high; if several are high anyway, priority is capture > shift > update, and the IR group is evaluated before the DR group, so only one action occurs.
- IR path:
  - cir1: ir_sr <= {IR_W-2 zeros, 2'b01}.
  - sir1: ir_sr <= {tdi, ir_sr[IR_W-1:1]}.
  - uir1: ir_q <= ir_sr.
- DR path, selected by ir_q:
  - BYPASS: cdr1 -> byp <= 0; sdr1 -> byp <= tdi.
  - IDCODE: cdr1 -> id_sr <= IDCODE_VAL; sdr1 -> shift right with tdi in at the MSB.
  - USER: cdr1 -> usr_sr <= user_in; sdr1 -> shift right with tdi in at the MSB; udr1 -> user_q <= usr_sr and user_upd = 1 for exactly that cycle.
  - udr1 under BYPASS/IDCODE: no effect, no user_upd pulse.
- TDO: on negedge tck, tdo <= (sir1 ? ir_sr[0] : sdr1 ? LSB of selected DR : 0), and tdo_en <= sir1 | sdr1. Relative to posedge tck, tdo has one half-cycle of latency.
- Shift length is unlimited. The bit shifted out after N cycles follows the shifted-in tdi stream; no wrap or saturation.
- Reset (trst=0, asynchronous, any time including mid-shift):
  - ir_q <= IDCODE opcode (BYPASS opcode when the feature is compiled out).
  - ir_sr <= {zeros, 01}; byp <= 0; id_sr <= IDCODE_VAL; usr_sr <= 0.
  - user_q <= 0; user_upd <= 0; tdo <= 0; tdo_en <= 0.
  - On release, nothing happens until the next strobe.
- ir_q changes only on uir1, so an in-progress DR scan is never re-routed by an IR shift.

Optional Feature:
- JTAG_IDCODE_EN defined: IDCODE register and opcode present; reset instruction is IDCODE.
- JTAG_IDCODE_EN undefined: no id_sr; opcode 1 decodes to BYPASS; reset instruction is BYPASS, so the first DR scan after reset returns 0 then tdi delayed by one cycle.

Decomposition:
- Package jtag_pkg: opcode constants (OP_BYPASS, OP_IDCODE, OP_USER), IR capture pattern, default IDCODE_VAL.
- One natural sub-module, jtag_shift_reg: parameterised width with capture/shift/update and negedge-safe LSB output. Instantiated for IR and USER; IDCODE uses it without update.

Test Plan:
- Reset, then a 32-cycle DR scan with tdi=0 -> tdo sequence is IDCODE_VAL LSB first (0x12345679), tdo_en high for 32 cycles.
- IR scan shifting 4'b0010 (LSB first), then uir1 -> tdo during the IR scan shows 1,0,0,0 (capture pattern); ir_q = 2.
- With USER selected and user_in=8'hA5, 8-cycle DR scan shifting in 8'h3C, then udr1 -> tdo bits = A5 LSB first; user_q=8'h3C; user_upd high for exactly one tck.
- IR = 4'b1111 (BYPASS), 5-cycle DR scan tdi=1,0,1,1,0 -> tdo = 0,1,0,1,1 (one-cycle delay); udr1 gives no user_upd.
- trst pulsed low mid USER DR shift (after 3 bits) -> all outputs at reset values immediately (asynchronously), ir_q = IDCODE; user_q unchanged from 0; a later scan returns IDCODE_VAL.
- Illegal opcode 4'b0111 loaded -> DR behaves as BYPASS (capture 0, one-bit delay).
